// File: rtl/tensor_acc_pkg.sv
// Shared width constants and sizing helpers for the tensor output accumulator
// and the result writeback stage that consumes its output.
package tensor_acc_pkg;

    localparam int DEF_NUM_IN = 4;
    localparam int DEF_IN_W   = 8;
    localparam int DEF_BIAS_W = 4;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_OUT_W  = 16;
    localparam int BEATS_W    = 16;

    function automatic int clog2_int(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // One guard bit beyond the lane growth keeps the bias add from overflowing.
    function automatic int sum_width(input int num_in, input int in_w);
        return in_w + clog2_int(num_in + 1) + 1;
    endfunction

    function automatic longint sat_max(input int out_w);
        return (longint'(1) <<< (out_w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int out_w);
        return -(longint'(1) <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/tensor_lane_sum_tree.sv
// Combinational signed sum of NUM_IN packed partial-product lanes plus a bias,
// every operand sign-extended to SUM_W before it is added.
module tensor_lane_sum_tree
    import tensor_acc_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int IN_W   = DEF_IN_W,
    parameter int BIAS_W = DEF_BIAS_W,
    parameter int SUM_W  = sum_width(NUM_IN, IN_W)
) (
    input  logic [NUM_IN*IN_W-1:0] i_lanes,
    input  logic [BIAS_W-1:0]      i_bias,
    output logic [SUM_W-1:0]       o_sum
);

    logic signed [SUM_W-1:0] w_total;

    always_comb begin
        // NOTE: assigned first on every pass so the block cannot infer a latch.
        w_total = SUM_W'($signed(i_bias));
        for (int i = 0; i < NUM_IN; i++) begin
            w_total = w_total + SUM_W'($signed(i_lanes[i*IN_W +: IN_W]));
        end
    end

    assign o_sum = w_total;

endmodule

// File: rtl/tensor_output_accumulator.sv
// Streaming K-tile accumulator: beat register -> lane sum -> group accumulate,
// with optional saturation and valid/ready flow control on both sides.
module tensor_output_accumulator
    import tensor_acc_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int IN_W   = DEF_IN_W,
    parameter int BIAS_W = DEF_BIAS_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_IN*IN_W-1:0] in_data,
    input  logic [BIAS_W-1:0]      in_bias,
    input  logic                   in_last,
    input  logic                   sat_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [BEATS_W-1:0]     out_beats,
    output logic                   sat_flag
);

    localparam int SUM_W = sum_width(NUM_IN, IN_W);
    localparam logic signed [ACC_W-1:0] ACC_MAX   = ACC_W'(sat_max(OUT_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN   = ACC_W'(sat_min(OUT_W));
    localparam logic [BEATS_W-1:0]      BEATS_MAX = '1;

    logic                    w_stall;
    logic [SUM_W-1:0]        w_sum;
    logic signed [ACC_W-1:0] w_final;
    logic                    w_over;
    logic                    w_under;
    logic [OUT_W-1:0]        w_result;
    logic [BEATS_W-1:0]      w_cnt_inc;

    logic                    r_b_valid;
    logic [NUM_IN*IN_W-1:0]  r_b_data;
    logic [BIAS_W-1:0]       r_b_bias;
    logic                    r_b_last;

    logic                    r_s1_valid;
    logic signed [SUM_W-1:0] r_s1_sum;
    logic                    r_s1_last;

    logic signed [ACC_W-1:0] r_acc;
    logic [BEATS_W-1:0]      r_cnt;
    logic                    r_out_valid;
    logic [OUT_W-1:0]        r_out_data;
    logic [BEATS_W-1:0]      r_out_beats;
    logic                    r_sat_flag;

    // A held result freezes the whole pipeline; nothing is ever dropped.
    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_b_valid <= 1'b0;
            r_b_data  <= '0;
            r_b_bias  <= '0;
            r_b_last  <= 1'b0;
        end else if (!w_stall) begin
            // NOTE: non-blocking so each stage samples its predecessor's pre-edge value.
            r_b_valid <= in_valid;
            r_b_data  <= in_data;
            r_b_bias  <= in_bias;
            r_b_last  <= in_last;
        end
    end

    tensor_lane_sum_tree #(
        .NUM_IN (NUM_IN),
        .IN_W   (IN_W),
        .BIAS_W (BIAS_W),
        .SUM_W  (SUM_W)
    ) u_sum_tree (
        .i_lanes (r_b_data),
        .i_bias  (r_b_bias),
        .o_sum   (w_sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_last  <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= r_b_valid;
            r_s1_sum   <= w_sum;
            r_s1_last  <= r_b_last;
        end
    end

    assign w_final   = r_acc + ACC_W'(r_s1_sum);
    assign w_over    = w_final > ACC_MAX;
    assign w_under   = w_final < ACC_MIN;
    assign w_cnt_inc = (r_cnt == BEATS_MAX) ? BEATS_MAX : r_cnt + BEATS_W'(1);

    always_comb begin
        w_result = w_final[OUT_W-1:0];
        if (sat_en && w_over) begin
            w_result = ACC_MAX[OUT_W-1:0];
        end else if (sat_en && w_under) begin
            w_result = ACC_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_beats <= '0;
            r_sat_flag  <= 1'b0;
        end else if (!w_stall) begin
            // A handshake and a new result on the same edge keeps valid high.
            r_out_valid <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
                if (r_s1_last) begin
                    r_out_data  <= w_result;
                    r_out_beats <= w_cnt_inc;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    if (sat_en && (w_over || w_under)) begin
                        r_sat_flag <= 1'b1;
                    end
                end else begin
                    r_acc <= w_final;
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_beats = r_out_beats;
    assign sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_tensor_output_accumulator.sv
// Scoreboard bench: stimulus pushes expected group results, an independent
// monitor pops and compares on every output handshake.
module tb_tensor_output_accumulator;

    localparam int NUM_IN = 4;
    localparam int IN_W   = 8;
    localparam int BIAS_W = 4;
    localparam int ACC_W  = 24;
    localparam int OUT_W  = 16;
    localparam longint OUT_MAX = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam longint OUT_MIN = -(longint'(1) <<< (OUT_W - 1));

    typedef struct {
        longint data;
        longint beats;
        bit     flag;
    } exp_t;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_IN*IN_W-1:0] in_data;
    logic [BIAS_W-1:0]      in_bias;
    logic                   in_last;
    logic                   sat_en;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       out_data;
    logic [15:0]            out_beats;
    logic                   sat_flag;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   accept_cyc = 0;
    bit   ready_random = 0;
    bit   ready_force  = 1;
    bit   sat_ref      = 0;

    tensor_output_accumulator #(
        .NUM_IN (NUM_IN),
        .IN_W   (IN_W),
        .BIAS_W (BIAS_W),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bias   (in_bias),
        .in_last   (in_last),
        .sat_en    (sat_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beats (out_beats),
        .sat_flag  (sat_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got no event, expected one (t=%0t)", name, $time);
    endtask

    function automatic logic [NUM_IN*IN_W-1:0] fill(input int v);
        logic [NUM_IN*IN_W-1:0] lanes;
        for (int i = 0; i < NUM_IN; i++) lanes[i*IN_W +: IN_W] = IN_W'(v);
        return lanes;
    endfunction

    task automatic push_exp(input longint d, input longint b, input bit f);
        exp_t e;
        e.data  = d;
        e.beats = b;
        e.flag  = f;
        exp_q.push_back(e);
    endtask

    // Reference: the group result is the plain integer sum of every lane and bias.
    task automatic push_model(input longint total, input int beats, input bit sat);
        longint m;
        longint w;
        m = longint'(1) <<< OUT_W;
        if (sat) begin
            w = total;
            if (total > OUT_MAX) begin
                w = OUT_MAX;
                sat_ref = 1;
            end else if (total < OUT_MIN) begin
                w = OUT_MIN;
                sat_ref = 1;
            end
        end else begin
            w = total % m;
            if (w < 0) w = w + m;
            if (w > OUT_MAX) w = w - m;
        end
        push_exp(w, (beats > 65535) ? 65535 : beats, sat_ref);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_beat(input logic [NUM_IN*IN_W-1:0] lanes, input int bias, input bit last);
        int  waited;
        bit  rdy;
        in_valid = 1'b1;
        in_data  = lanes;
        in_bias  = BIAS_W'(bias);
        in_last  = last;
        waited   = 0;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            waited++;
            if (waited > 1000) begin
                fail_now("accept_timeout");
                break;
            end
        end
        #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 2000) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
        end
        idle(3);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_beats", longint'(out_beats), 0);
        check("rst_sat_flag", longint'(sat_flag), 0);
        exp_q.delete();
        sat_ref = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 1);
    endtask

    task automatic random_phase(input int n_groups, input bit sat);
        int n_beats;
        int v;
        int bias;
        longint total;
        logic [NUM_IN*IN_W-1:0] lanes;
        sat_en = sat;
        for (int g = 0; g < n_groups; g++) begin
            n_beats = int'($urandom_range(1, 6));
            total = 0;
            for (int b = 0; b < n_beats; b++) begin
                for (int l = 0; l < NUM_IN; l++) begin
                    v = int'($urandom_range(0, 255)) - 128;
                    lanes[l*IN_W +: IN_W] = IN_W'(v);
                    total += v;
                end
                bias = int'($urandom_range(0, 15)) - 8;
                total += bias;
                if (b == n_beats - 1) push_model(total, n_beats, sat);
                send_beat(lanes, bias, b == n_beats - 1);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            end
        end
        drain();
    endtask

    initial begin : ready_driver
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = ready_random ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got %0d, expected no result", $signed(out_data));
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", longint'($signed(out_data)), e.data);
                    check("out_beats", longint'(out_beats), e.beats);
                    check("sat_flag", longint'(sat_flag), e.flag);
                end
            end
        end
    end

    initial begin : stimulus
        int a_cyc;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_bias  = '0;
        in_last  = 1'b0;
        sat_en   = 1'b0;
        repeat (2) @(negedge clk);
        check("init_out_valid", longint'(out_valid), 0);
        check("init_out_data", longint'(out_data), 0);
        check("init_out_beats", longint'(out_beats), 0);
        check("init_sat_flag", longint'(sat_flag), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("init_in_ready", longint'(in_ready), 1);

        // Single beat with latency: result visible after the second edge.
        push_exp(9, 1, 0);
        send_beat({8'(4), 8'(3), 8'(2), 8'(1)}, -1, 1'b1);
        @(negedge clk);
        check("lat_before_n1", longint'(out_valid), 0);
        @(negedge clk);
        check("lat_after_n1", longint'(out_valid), 0);
        @(negedge clk);
        check("lat_after_n2", longint'(out_valid), 1);
        @(posedge clk);
        #1;
        drain();

        // Three-beat group followed back-to-back by a single-beat group.
        push_exp(1545, 3, 0);
        push_exp(-520, 1, 0);
        send_beat(fill(127), 7, 1'b0);
        send_beat(fill(127), 7, 1'b0);
        send_beat(fill(127), 7, 1'b1);
        a_cyc = accept_cyc;
        send_beat(fill(-128), -8, 1'b1);
        check("no_bubble", accept_cyc - a_cyc, 1);
        drain();

        // Idle cycles inside a group.
        push_exp(60, 3, 0);
        send_beat(fill(5), 0, 1'b0);
        idle(2);
        send_beat(fill(5), 0, 1'b0);
        idle(3);
        send_beat(fill(5), 0, 1'b1);
        drain();

        // Backpressure: the first result is held, later ones wait in flight.
        ready_force = 1'b0;
        idle(1);
        push_exp(4, 1, 0);
        push_exp(8, 1, 0);
        push_exp(12, 1, 0);
        fork
            begin
                send_beat(fill(1), 0, 1'b1);
                send_beat(fill(2), 0, 1'b1);
                send_beat(fill(3), 0, 1'b1);
            end
            begin
                int waited;
                waited = 0;
                @(negedge clk);
                while (!out_valid && waited < 50) begin
                    @(negedge clk);
                    waited++;
                end
                if (!out_valid) fail_now("bp_result_timeout");
                repeat (5) begin
                    check("bp_in_ready", longint'(in_ready), 0);
                    check("bp_out_valid", longint'(out_valid), 1);
                    check("bp_out_data", longint'($signed(out_data)), 4);
                    check("bp_out_beats", longint'(out_beats), 1);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                ready_force = 1'b1;
            end
        join
        drain();

        // Reset in the middle of a group discards the partial sum.
        send_beat(fill(10), 0, 1'b0);
        send_beat(fill(10), 0, 1'b0);
        idle(3);
        pulse_reset();
        push_exp(4, 1, 0);
        send_beat(fill(1), 0, 1'b1);
        drain();

        // Saturating and wrapping a 70-beat group totalling 36050.
        sat_en = 1'b1;
        push_exp(32767, 70, 1);
        for (int i = 0; i < 70; i++) send_beat(fill(127), 7, i == 69);
        drain();
        check("sat_flag_sticky", longint'(sat_flag), 1);
        pulse_reset();
        sat_en = 1'b0;
        push_exp(-29486, 70, 0);
        for (int i = 0; i < 70; i++) send_beat(fill(127), 7, i == 69);
        drain();
        check("wrap_sat_flag", longint'(sat_flag), 0);

        // Randomized groups against the reference model, with random backpressure.
        ready_random = 1'b1;
        random_phase(40, 1'b0);
        random_phase(40, 1'b1);
        ready_random = 1'b0;
        idle(5);

        check("queue_empty", longint'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tensor_output_accumulator.md
Name: tensor_output_accumulator

Overview:
Parametrised successor to the single-shot output adder. It sums NUM_IN signed partial products plus a signed bias each beat, then accumulates the beats of a K-tile group into one signed result. Optional saturation and a valid/ready handshake on both sides. It sits between the cross-product array and the result writeback, and replaces one-shot start/done sequencing with continuous streaming under backpressure.

Parameters:
NUM_IN, 4, partial-product lanes per beat (≥2)
IN_W, 8, signed width of each lane
BIAS_W, 4, signed width of bias
ACC_W, 24, internal signed accumulator width (≥ OUT_W)
OUT_W, 16, signed result width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
in_valid  in  1  beat valid
in_ready  out  1  block can accept a beat
in_data  in  NUM_IN*IN_W  lanes packed; lane i = bits [i*IN_W +: IN_W], signed
in_bias  in  BIAS_W  signed bias for this beat
in_last  in  1  final beat of group
sat_en  in  1  1 = saturate to OUT_W, 0 = wrap (truncate)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  OUT_W  signed group result
out_beats  out  16  beats in the delivered group (saturates at 0xFFFF)
sat_flag  out  1  sticky: some result was clamped; cleared only by reset

Behaviour:
- Reset (rst=0, asynchronous): all valids 0, accumulator 0, beat counter 0, out_data 0, out_beats 0, sat_flag 0. in_ready reads 1 once reset releases.
- A beat transfers on a rising edge with in_valid && in_ready. A result transfers with out_valid && out_ready.
- stall = out_valid && !out_ready. in_ready = !stall (combinational). On stall, all pipeline registers hold.
- Stage 1 (registered): s1_sum = sign-extended sum of all lanes + sign-extended bias, SUM_W = IN_W + clog2(NUM_IN+1) + 1 bits. Also registers s1_last, s1_valid.
- Stage 2 (registered), on s1_valid && !stall:
  - last=0: acc <= acc + s1_sum; cnt++.
  - last=1: final = acc + s1_sum (ACC_W arithmetic); out_data <= sat_en ? clamp(final, -2^(OUT_W-1), 2^(OUT_W-1)-1) : final[OUT_W-1:0]; out_beats <= cnt+1; out_valid <= 1; acc <= 0; cnt <= 0.
  - sat_flag sets if sat_en and clamping occurred.
- sat_en is sampled at stage 2 on the last beat.
- Latency: in_last accepted at edge N → out_valid=1 after edge N+2, with no stall.
- Throughput: one beat per cycle. Back-to-back groups need no bubble.
- Output handshake:
  - Leaving out_valid: clears on handshake unless a new result is produced on the same edge, in which case it stays 1 with new data.
  - Holding: while out_valid && !out_ready, out_data and out_beats are stable.
- Accumulator is not checked for ACC_W overflow (wraps). Groups must keep |sum| < 2^(ACC_W-1).
- A single-beat group (in_last on the first beat) is legal.
- Reset mid-group discards the partial accumulation and any pending result. The next beat starts a fresh group.
- in_valid=0 cycles inside a group are legal and do not disturb acc.

Decomposition:
- Package tensor_acc_pkg: SUM_W/clog2 helper function, saturation-bounds functions, and the default width constants shared with the writeback stage.
- One sub-module is natural: tensor_lane_sum_tree (combinational signed adder tree over NUM_IN lanes + bias, parametrised by NUM_IN/IN_W/BIAS_W), instantiated in stage 1.

Test Plan:
- Single beat: lanes {1,2,3,4}, bias -1, last=1, out_ready=1 → out_data=9, out_beats=1, out_valid exactly 2 edges after acceptance.
- Three-beat group: each beat lanes {127,127,127,127}, bias 7, last on beat 3 → out_data=1545, out_beats=3. Then immediate next group of lanes {-128×4}, bias -8, last=1 → out_data=-520 with no bubble.
- Saturation: 70 beats of {127×4}, bias 7 (total 36050).
  - sat_en=1 → out_data=32767, sat_flag=1.
  - Repeat after reset with sat_en=0 → out_data=-29486, sat_flag=0.
- Backpressure: out_ready=0 when result pending → in_ready=0, out_data/out_beats stable 5 cycles. Release → handshake, next in-flight result follows without loss or duplication.
- Reset mid-group: 2 beats of {10,10,10,10}, bias 0. Assert rst=0 asynchronously between edges → outputs 0 immediately. Then one beat {1,1,1,1}, last=1 → out_data=4, out_beats=1.
- Idle gaps: 3-beat group of {5,5,5,5}, bias 0, with in_valid=0 cycles between beats → out_data=60, out_beats=3.
